// File: rtl/rvfi_monitor.sv
// rvfi_monitor: consumer-side checker for a hart's RVFI retirement stream.
//
// Every retirement packet is sampled. The monitor checks instruction order,
// PC continuity, x0 integrity, and that no packet arrives after halt.
// With RVFI_MONITOR_TRACE_EN defined, each accepted packet also pushes its
// {pc, insn} pair into a trace FIFO, which a valid/ready port drains.
// With the macro undefined, the trace outputs are tied to zero.
//
// Parameters:
//   DEPTH           trace FIFO entries (power of two, >= 2)
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   rvfi_*          retirement packet from the hart (no backpressure)
//   retired         count of accepted packets (64-bit wrap)
//   halted          sticky: a halt packet was accepted
//   err_flags       sticky errors [0] order [1] pc [2] x0 [3] valid after halt
//   err_order       rvfi_order of the packet that raised the first error
//   trace_valid/trace_ready/trace_pc/trace_insn  trace FIFO head port
//   trace_overflow  sticky: an accepted packet was dropped on a full FIFO
//
// Trace handshake: the head entry transfers on a rising edge where
// trace_valid && trace_ready. trace_valid never depends on trace_ready.
// trace_pc/trace_insn are stable while trace_valid is high and not taken.
module rvfi_monitor #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  output logic [63:0] retired,
  output logic        halted,
  output logic [3:0]  err_flags,
  output logic [63:0] err_order,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_insn,
  output logic        trace_overflow
);

  logic [63:0] exp_order;
  logic [31:0] exp_pc;
  logic        pc_known;
  logic        accept;
  logic [3:0]  new_err;

  // Trapped packets are checked and tracked exactly like normal ones.
  logic unused_trap;
  assign unused_trap = rvfi_trap;

  always_comb begin
    accept     = rvfi_valid && !halted;
    new_err    = 4'd0;
    new_err[0] = accept && (rvfi_order != exp_order);
    new_err[1] = accept && pc_known && (rvfi_pc_rdata != exp_pc);
    new_err[2] = accept && (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);
    new_err[3] = rvfi_valid && halted;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_order <= 64'd0;
      exp_pc    <= 32'd0;
      pc_known  <= 1'b0;
      retired   <= 64'd0;
      halted    <= 1'b0;
      err_flags <= 4'd0;
      err_order <= 64'd0;
    end else begin
      if (accept) begin
        // Resync on the observed order so that a single gap reports once.
        exp_order <= rvfi_order + 64'd1;
        exp_pc    <= rvfi_pc_wdata;
        pc_known  <= 1'b1;
        retired   <= retired + 64'd1;
        if (rvfi_halt) halted <= 1'b1;
      end
      err_flags <= err_flags | new_err;
      // Capture only on the first error. Later errors keep this value.
      if ((err_flags == 4'd0) && (new_err != 4'd0)) err_order <= rvfi_order;
    end
  end

`ifdef RVFI_MONITOR_TRACE_EN
  localparam int AW = $clog2(DEPTH);

  logic [63:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic        full, pop, push;
  logic [63:0] head_next;

  always_comb begin
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop       = trace_valid && trace_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push      = accept && (!full || pop);
    wr_next   = push ? wr_ptr + {{AW{1'b0}}, 1'b1} : wr_ptr;
    rd_next   = pop  ? rd_ptr + {{AW{1'b0}}, 1'b1} : rd_ptr;
    head_next = mem[rd_next[AW-1:0]];
    // Pushing into a FIFO that is empty after the pop: the new entry
    // becomes the head. Forward it because the memory write lands this edge.
    if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
      head_next = {rvfi_pc_rdata, rvfi_insn};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {rvfi_pc_rdata, rvfi_insn};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trace_valid    <= 1'b0;
      trace_pc       <= 32'd0;
      trace_insn     <= 32'd0;
      trace_overflow <= 1'b0;
    end else begin
      wr_ptr      <= wr_next;
      rd_ptr      <= rd_next;
      trace_valid <= (wr_next != rd_next);
      if (wr_next != rd_next) {trace_pc, trace_insn} <= head_next;
      if (accept && full && !pop) trace_overflow <= 1'b1;
    end
  end
`else
  assign trace_valid    = 1'b0;
  assign trace_pc       = 32'd0;
  assign trace_insn     = 32'd0;
  assign trace_overflow = 1'b0;

  logic [32:0] unused_trace;
  assign unused_trace = {trace_ready, rvfi_insn};
`endif

endmodule

// File: tb/tb_rvfi_monitor.sv
module tb_rvfi_monitor;
  localparam int DEPTH = 8;
`ifdef RVFI_MONITOR_TRACE_EN
  localparam logic TR = 1'b1;
`else
  localparam logic TR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic        rvfi_halt;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [63:0] retired;
  logic        halted;
  logic [3:0]  err_flags;
  logic [63:0] err_order;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_insn;
  logic        trace_overflow;

  rvfi_monitor #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .retired(retired), .halted(halted), .err_flags(err_flags),
    .err_order(err_order), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_pc(trace_pc), .trace_insn(trace_insn),
    .trace_overflow(trace_overflow)
  );

  // ---------------- scoreboard ----------------
  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  bit          tb_halted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    rvfi_valid = 1'b0;
    trace_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    tb_halted = 1'b0;
  endtask

  // Drives one packet for one cycle. If pop is set, the current head is
  // checked against the scoreboard and taken in the same cycle.
  task automatic send(input logic [63:0] order, input logic [31:0] pc,
                      input logic [31:0] npc, input logic [4:0] rd,
                      input logic [31:0] wd, input bit halt, input bit trap,
                      input bit pop);
    logic [31:0] insn;
    logic [63:0] h;
    insn = $urandom;
`ifdef RVFI_MONITOR_TRACE_EN
    if (pop) begin
      chk("pop_valid", {63'd0, trace_valid}, 64'd1);
      if (exp_q.size() > 0) begin
        h = exp_q.pop_front();
        chk("pop_pc", {32'd0, trace_pc}, {32'd0, h[63:32]});
        chk("pop_insn", {32'd0, trace_insn}, {32'd0, h[31:0]});
      end
      trace_ready = 1'b1;
    end
    if (!tb_halted && exp_q.size() < DEPTH) exp_q.push_back({pc, insn});
`else
    if (pop) chk("trace_valid_off", {63'd0, trace_valid}, 64'd0);
    h = 64'd0;
`endif
    rvfi_order    = order;
    rvfi_insn     = insn;
    rvfi_pc_rdata = pc;
    rvfi_pc_wdata = npc;
    rvfi_rd_addr  = rd;
    rvfi_rd_wdata = wd;
    rvfi_halt     = halt;
    rvfi_trap     = trap;
    rvfi_valid    = 1'b1;
    @(negedge clk);
    rvfi_valid  = 1'b0;
    rvfi_halt   = 1'b0;
    rvfi_trap   = 1'b0;
    trace_ready = 1'b0;
    if (halt) tb_halted = 1'b1;
  endtask

`ifdef RVFI_MONITOR_TRACE_EN
  task automatic drain(input int n);
    logic [63:0] h;
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", {63'd0, trace_valid}, 64'd1);
      if (exp_q.size() > 0) begin
        h = exp_q.pop_front();
        chk("drain_pc", {32'd0, trace_pc}, {32'd0, h[63:32]});
        chk("drain_insn", {32'd0, trace_insn}, {32'd0, h[31:0]});
      end
      trace_ready = 1'b1;
      @(negedge clk);
      trace_ready = 1'b0;
    end
  endtask
`endif

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; rvfi_valid = 1'b0; rvfi_order = 64'd0; rvfi_insn = 32'd0;
    rvfi_trap = 1'b0; rvfi_halt = 1'b0; rvfi_pc_rdata = 32'd0;
    rvfi_pc_wdata = 32'd0; rvfi_rd_addr = 5'd0; rvfi_rd_wdata = 32'd0;
    trace_ready = 1'b0; tb_halted = 1'b0;

    do_reset();
    chk("rst_retired", retired, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_err_flags", {60'd0, err_flags}, 64'd0);
    chk("rst_err_order", err_order, 64'd0);
    chk("rst_trace_valid", {63'd0, trace_valid}, 64'd0);
    chk("rst_trace_pc", {32'd0, trace_pc}, 64'd0);
    chk("rst_trace_insn", {32'd0, trace_insn}, 64'd0);
    chk("rst_overflow", {63'd0, trace_overflow}, 64'd0);

    // Ten in-order packets, streamed through the trace port.
    for (int i = 0; i < 10; i++) begin
      send(64'(i), 32'(i * 4), 32'(i * 4 + 4), 5'd1, $urandom, 1'b0, 1'b0, i > 0);
      if (i == 0) chk("trace_latency", {63'd0, trace_valid}, {63'd0, TR});
    end
    chk("seq_retired", retired, 64'd10);
    chk("seq_flags", {60'd0, err_flags}, 64'd0);
`ifdef RVFI_MONITOR_TRACE_EN
    drain(1);
`endif
    chk("seq_empty", {63'd0, trace_valid}, 64'd0);

    // Order gap 0,1,3,4.
    do_reset();
    send(64'd0, 32'h0, 32'h4, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    send(64'd1, 32'h4, 32'h8, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    chk("order_pre", {60'd0, err_flags}, 64'd0);
    send(64'd3, 32'h8, 32'hc, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    chk("order_flag", {60'd0, err_flags}, 64'd1);
    chk("order_err_order", err_order, 64'd3);
    send(64'd4, 32'hc, 32'h10, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    chk("order_resync", {60'd0, err_flags}, 64'd1);
    chk("order_err_keep", err_order, 64'd3);
    chk("order_retired", retired, 64'd4);

    // PC discontinuity.
    do_reset();
    send(64'd0, 32'h0, 32'h100, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    send(64'd1, 32'h104, 32'h108, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    chk("pc_flag", {60'd0, err_flags}, 64'd2);
    chk("pc_err_order", err_order, 64'd1);

    // Trap redirect followed correctly; x0 written with zero is legal.
    do_reset();
    send(64'd0, 32'h0, 32'h80, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    send(64'd1, 32'h80, 32'h84, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("trap_ok", {60'd0, err_flags}, 64'd0);
    chk("trap_retired", retired, 64'd2);

    // x0 written with nonzero data.
    do_reset();
    send(64'd0, 32'h0, 32'h4, 5'd0, 32'h5, 1'b0, 1'b0, 1'b0);
    chk("x0_flag", {60'd0, err_flags}, 64'd4);

    // Order and x0 errors in one packet, then a later PC error.
    do_reset();
    send(64'd0, 32'h0, 32'h4, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    send(64'd7, 32'h4, 32'h8, 5'd0, 32'h5, 1'b0, 1'b0, 1'b0);
    chk("multi_flags", {60'd0, err_flags}, 64'd5);
    chk("multi_err_order", err_order, 64'd7);
    send(64'd8, 32'h40, 32'h44, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    chk("multi_pc_flags", {60'd0, err_flags}, 64'd7);
    chk("multi_err_order_keep", err_order, 64'd7);

    // Halt, then two more packets.
    do_reset();
    send(64'd0, 32'h0, 32'h4, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    send(64'd1, 32'h4, 32'h8, 5'd1, 32'h1, 1'b1, 1'b0, 1'b0);
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_flags", {60'd0, err_flags}, 64'd0);
    chk("halt_retired", retired, 64'd2);
    send(64'd2, 32'h8, 32'hc, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    send(64'd3, 32'hc, 32'h10, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    chk("post_halt_flags", {60'd0, err_flags}, 64'd8);
    chk("post_halt_retired", retired, 64'd2);
    chk("post_halt_err_order", err_order, 64'd2);
`ifdef RVFI_MONITOR_TRACE_EN
    drain(2);
`endif
    chk("post_halt_untraced", {63'd0, trace_valid}, 64'd0);

    // Overflow: nine packets with no consumer, then full with pop and push.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(64'(i), 32'(i * 4), 32'(i * 4 + 4), 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    end
    chk("ovf_flag", {63'd0, trace_overflow}, {63'd0, TR});
    chk("ovf_no_err", {60'd0, err_flags}, 64'd0);
    send(64'd9, 32'd36, 32'd40, 5'd1, 32'h1, 1'b0, 1'b0, 1'b1);
    chk("ovf_retired", retired, 64'd10);
`ifdef RVFI_MONITOR_TRACE_EN
    drain(8);
`endif
    chk("ovf_empty", {63'd0, trace_valid}, 64'd0);

    // Reset mid-stream with a packet presented during reset.
    send(64'd10, 32'd40, 32'd44, 5'd0, 32'h9, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    rvfi_order = 64'd11; rvfi_pc_rdata = 32'd44; rvfi_pc_wdata = 32'd48;
    rvfi_rd_addr = 5'd0; rvfi_rd_wdata = 32'h9; rvfi_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rvfi_valid = 1'b0;
    exp_q.delete();
    tb_halted = 1'b0;
    chk("midrst_retired", retired, 64'd0);
    chk("midrst_flags", {60'd0, err_flags}, 64'd0);
    chk("midrst_overflow", {63'd0, trace_overflow}, 64'd0);
    chk("midrst_trace_valid", {63'd0, trace_valid}, 64'd0);
    send(64'd0, 32'h200, 32'h204, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0);
    chk("after_rst_flags", {60'd0, err_flags}, 64'd0);
    chk("after_rst_retired", retired, 64'd1);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
